// File: rtl/mult_pkg.sv
// mult_pkg: types, default sizes and sizing helpers shared by the Wallace tree multiplier blocks.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, ADD, DONE} cpa_state_t;

   localparam int WIDTH_DEF = 32;
   localparam int CHUNK_DEF = 8;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Index width never drops below one bit, even for a single chunk.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cpa_chunk_add.sv
// cpa_chunk_add: combinational W-bit adder with carry in and carry out.
module cpa_chunk_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         cout_o
);

   assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/cpa_serial_adder.sv
// cpa_serial_adder: resolves the compressor tree sum/carry pair into a binary result, CHUNK bits per cycle.
module cpa_serial_adder
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_vec,
   input  logic [WIDTH-1:0] carry_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IW     = idx_width(NCHUNK);

   if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("cpa_serial_adder: WIDTH must be a multiple of CHUNK");
   end

   cpa_state_t       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] cvec_q, cvec_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_co;

   // Operand copies shift right each cycle so the adder always sees their low chunk.
   cpa_chunk_add #(.W(CHUNK)) u_add (
      .a_i   (sum_q[CHUNK-1:0]),
      .b_i   (cvec_q[CHUNK-1:0]),
      .cin_i (carry_q),
      .s_o   (chunk_s),
      .cout_o(chunk_co)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      sum_d    = sum_q;
      cvec_d   = cvec_q;
      result_d = result_q;
      cout_d   = cout_q;
      if (state_q == IDLE && in_valid) begin
         sum_d   = sum_vec;
         cvec_d  = carry_vec;
         carry_d = 1'b0;
         idx_d   = '0;
         state_d = ADD;
      end else if (state_q == ADD) begin
         result_d[idx_q*CHUNK +: CHUNK] = chunk_s;
         carry_d = chunk_co;
         sum_d   = sum_q >> CHUNK;
         cvec_d  = cvec_q >> CHUNK;
         idx_d   = idx_q + IW'(1);
         if (idx_q == IW'(NCHUNK - 1)) begin
            cout_d  = chunk_co;
            state_d = DONE;
         end
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sum_q    <= '0;
         cvec_q   <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         sum_q    <= sum_d;
         cvec_q   <= cvec_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_cpa_serial_adder.sv
// tb_cpa_serial_adder: directed checks of the serial carry-propagate adder at WIDTH=32, CHUNK=8.
module tb_cpa_serial_adder;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, cout;
   logic [31:0] sum_vec, carry_vec, result;
   int          checks = 0;
   int          errors = 0;

   cpa_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum_vec  (sum_vec),
      .carry_vec(carry_vec),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .cout     (cout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] c);
      int n = 0;
      sum_vec   = s;
      carry_vec = c;
      in_valid  = 1'b1;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("launch_timeout", 32'(n), 32'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int          lat, k, got, cyc;
      int          t[3];
      logic        seen, pre_rdy, pre_ov, pre_co;
      logic [31:0] held, pre_res;
      logic [31:0] ops_s[3], ops_c[3];
      logic [32:0] gold[3];
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_vec = '0; carry_vec = '0;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      // chunk-boundary carry
      launch(32'h0000_00FF, 32'h0000_0001);
      chk("t1_busy_in_ready", 32'(in_ready), 32'd0);
      wait_out(lat);
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_result", result, 32'h0000_0100);
      chk("t1_cout", 32'(cout), 32'd0);
      drain();
      chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
      chk("t1_in_ready_back", 32'(in_ready), 32'd1);
      // full ripple
      launch(32'hFFFF_FFFF, 32'h0000_0001);
      wait_out(lat);
      chk("t2_latency", 32'(lat), 32'd4);
      chk("t2_result", result, 32'h0000_0000);
      chk("t2_cout", 32'(cout), 32'd1);
      drain();
      // backpressure with changing inputs and in_valid held
      launch(32'h0F0F_0F0F, 32'h0101_0101);
      wait_out(lat);
      chk("t3_latency", 32'(lat), 32'd4);
      held = result;
      chk("t3_result", held, 32'h1010_1010);
      sum_vec = 32'h8000_0000; carry_vec = 32'h8000_0000; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_result", result, 32'h1010_1010);
         chk("t3_hold_cout", 32'(cout), 32'd0);
         chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
         chk("t3_hold_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_after_hs_in_ready", 32'(in_ready), 32'd1);
      chk("t3_after_hs_out_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      chk("t3_second_accepted", 32'(in_ready), 32'd0);
      wait_out(lat);
      chk("t3_second_latency", 32'(lat), 32'd4);
      chk("t3_second_result", result, 32'h0000_0000);
      chk("t3_second_cout", 32'(cout), 32'd1);
      drain();
      // reset after chunk 1
      launch(32'h1234_5678, 32'h1111_1111);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t4_rst_result", result, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen |= out_valid;
      end
      chk("t4_no_out_valid", 32'(seen), 32'd0);
      chk("t4_idle_in_ready", 32'(in_ready), 32'd1);
      launch(32'h0000_0003, 32'h0000_0004);
      wait_out(lat);
      chk("t4_latency", 32'(lat), 32'd4);
      chk("t4_result", result, 32'h0000_0007);
      drain();
      // 0xFFFF * 0xFFFF as a redundant pair
      launch(32'hAAAA_5555, 32'h5553_AAAC);
      wait_out(lat);
      chk("t5_latency", 32'(lat), 32'd4);
      chk("t5_result", result, 32'hFFFE_0001);
      chk("t5_cout", 32'(cout), 32'd0);
      drain();
      // back-to-back throughput
      for (int i = 0; i < 3; i++) begin
         ops_s[i] = $urandom;
         ops_c[i] = $urandom;
         gold[i]  = {1'b0, ops_s[i]} + {1'b0, ops_c[i]};
      end
      k = 0; got = 0; cyc = 0;
      sum_vec = ops_s[0]; carry_vec = ops_c[0];
      in_valid = 1'b1; out_ready = 1'b1;
      while (got < 3 && cyc < 100) begin
         pre_rdy = in_ready;
         pre_ov  = out_valid;
         pre_res = result;
         pre_co  = cout;
         step();
         cyc++;
         if (pre_rdy && k < 3) begin
            t[k] = cyc;
            k++;
            if (k < 3) begin
               sum_vec = ops_s[k]; carry_vec = ops_c[k];
            end else in_valid = 1'b0;
         end
         if (pre_ov) begin
            chk("t6_result", pre_res, gold[got][31:0]);
            chk("t6_cout", 32'(pre_co), 32'(gold[got][32]));
            got++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t6_results_seen", 32'(got), 32'd3);
      chk("t6_accepts_seen", 32'(k), 32'd3);
      if (k == 3) begin
         chk("t6_interval_01", 32'(t[1] - t[0]), 32'd6);
         chk("t6_interval_12", 32'(t[2] - t[1]), 32'd6);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpa_serial_adder.md
# cpa_serial_adder

Final carry-propagate stage of the Wallace tree multiplier. It sits directly downstream of the 4:2 compressor tree and takes the redundant sum/carry vector pair that the tree produces. It resolves the pair into one binary product, CHUNK bits per clock, using a registered inter-chunk carry. Operands arrive and results leave on valid/ready handshakes, so the tree and the multiplier result register can stall independently.

## Interface
- WIDTH, 32: operand/result width (2N for an NxN multiplier); must be a multiple of CHUNK.
- CHUNK, 8: bits resolved per cycle; NCHUNK = WIDTH/CHUNK (≥1).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  sum_vec/carry_vec are valid.
- in_ready  output  1  block can accept an operand pair.
- sum_vec  input  WIDTH  tree sum vector.
- carry_vec  input  WIDTH  tree carry vector, already weight-aligned by the tree (no shift here).
- out_valid  output  1  result/cout are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  (sum_vec + carry_vec) mod 2^WIDTH.
- cout  output  1  bit WIDTH of the full sum (overflow out of MSB).

## Operation
- FSM states IDLE, ADD, DONE; reset state IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch both vectors, clear carry register, clear chunk index idx, go to ADD.
- ADD:
  - in_ready = 0.
  - Each cycle: result[idx*CHUNK +: CHUNK] and carry register ← sum_chunk + carry_chunk + carry register; idx++.
  - After chunk NCHUNK-1 is written: cout ← final carry, go to DONE.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - On out_ready: go to IDLE.
  - result and cout hold stable while out_ready = 0.
- in_ready is asserted only in IDLE; no overlap of the input and output handshakes.
- Latched operands are private copies: sum_vec/carry_vec may change freely after the accepting edge.
- result content is undefined to consumers outside DONE (partial chunks visible during ADD); only out_valid qualifies it.
- NCHUNK = 1: ADD lasts exactly one cycle.

## Timing
- Reset (rst high at an edge), values after that edge:
  - State IDLE, idx 0, carry register 0.
  - out_valid 0, result 0, cout 0.
  - in_ready 0 while rst is high; in_ready 1 in the first cycle after rst deasserts.
- Acceptance at edge E0 (IDLE & in_valid).
- Chunks 0..NCHUNK-1 are resolved at edges E1..E_NCHUNK.
- out_valid goes high after E_NCHUNK, i.e. latency NCHUNK cycles from acceptance.
- Output handshake at the first edge with DONE & out_ready → IDLE; the next acceptance is possible one edge later.
- Minimum initiation interval: NCHUNK+2 cycles.
- Reset mid-ADD or mid-DONE: operation is discarded, out_valid drops after that edge, and no partial result is ever presented.
- in_valid held high while in ADD/DONE: ignored; the same data is accepted on return to IDLE if still presented.

## Structure
- Shared package mult_pkg holds:
  - cpa_state_t enum (IDLE, ADD, DONE).
  - Default WIDTH/CHUNK localparams, shared with the compressor tree.
  - A function computing NCHUNK and the idx width, $clog2(NCHUNK) with a minimum of 1.
- One sub-module: cpa_chunk_add, a combinational CHUNK-bit adder with cin/cout; the parent holds all registers and the FSM.
- Static assertion: WIDTH % CHUNK == 0.

## Test plan
1. Chunk-boundary carry: sum=0x0000_00FF, carry=0x0000_0001 with WIDTH=32, CHUNK=8 → result=0x0000_0100, cout=0, out_valid exactly 4 cycles after acceptance.
2. Full ripple across all chunks: sum=0xFFFF_FFFF, carry=0x0000_0001 → result=0x0000_0000, cout=1.
3. Backpressure: out_ready low for 5 cycles in DONE, with sum/carry inputs changed and in_valid held high → result/cout stable, in_ready=0, second operand accepted only after the handshake.
4. Reset mid-operation: rst pulsed after chunk 1 of sum=0x1234_5678, carry=0x1111_1111 → out_valid never rises. The next operation (0x0000_0003 + 0x0000_0004) gives result=0x0000_0007.
5. End-to-end with the compressor tree: vectors from 16x16 operands 0xFFFF×0xFFFF → result=0xFFFE_0001, cout=0.
6. Throughput: in_valid and out_ready held high for 3 back-to-back random operands → acceptances spaced exactly NCHUNK+2=6 cycles apart, each result matching a golden sum.
